// File: rtl/lsu_data_memory_if.sv
// Request/response bus between the MEM stage and lsu_data_memory.
// The master drives requests; the slave (the memory) returns responses.
interface lsu_data_memory_if #(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [XLEN-1:0] req_addr;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;

    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/lsu_data_memory.sv
// Load/store data memory with sub-word access, configurable latency and valid/ready handshake.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of masking the low address bits.
module lsu_data_memory #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic              clk,
    input logic              reset,
    lsu_data_memory_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [XLEN-1:0] mem [DEPTH];

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic            r_write;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_fault;

    logic [1:0]      w_state_d;
    logic [3:0]      w_cnt_d;
    logic            w_accept;
    logic            w_commit;
    logic            w_op_write;
    logic [XLEN-1:0] w_op_addr;
    logic [2:0]      w_op_funct3;
    logic [XLEN-1:0] w_op_wdata;
    logic [2:0]      w_size_m1;
    logic [2:0]      w_lane;
    logic            w_misal;
    logic            w_align_fault;
    logic [XLEN-4:0] w_idx;
    logic            w_fault;
    logic [XLEN-1:0] w_word;
    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_wshift;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merged;
    logic [7:0]      w_bmask_base;
    logic [7:0]      w_bmask;

    assign bus.req_ready  = reset && (r_state != ST_WAIT);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_fault = r_fault;

    assign w_accept = bus.req_valid && bus.req_ready;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    w_cnt_d   = 4'd0;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_d = ST_RESP;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // RESP is only ever entered (or re-entered) by completing an access.
    assign w_commit = (w_state_d == ST_RESP);

    // With no wait states the access commits on the accept edge, so use the live request.
    assign w_op_write  = (WAIT_CYCLES == 0) ? bus.req_write  : r_write;
    assign w_op_addr   = (WAIT_CYCLES == 0) ? bus.req_addr   : r_addr;
    assign w_op_funct3 = (WAIT_CYCLES == 0) ? bus.req_funct3 : r_funct3;
    assign w_op_wdata  = (WAIT_CYCLES == 0) ? bus.req_wdata  : r_wdata;

    // Access size minus one; the 3-bit shift wraps 8 to 0 so LD/SD yield 7.
    assign w_size_m1 = (3'd1 << w_op_funct3[1:0]) - 3'd1;
    assign w_misal   = |(w_op_addr[2:0] & w_size_m1);
    assign w_lane    = w_op_addr[2:0] & ~w_size_m1;
    assign w_idx     = w_op_addr[XLEN-1:3];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_align_fault = w_misal;
`else
    assign w_align_fault = 1'b0;
`endif

    assign w_fault = (w_idx >= (XLEN-3)'(DEPTH))
                   || (w_op_write ? w_op_funct3[2] : (w_op_funct3 == 3'b111))
                   || w_align_fault;

    assign w_word   = mem[w_idx[AW-1:0]];
    assign w_shift  = w_word >> {w_lane, 3'b000};
    assign w_wshift = w_op_wdata << {w_lane, 3'b000};

    always_comb begin
        w_load = '0;
        case (w_op_funct3)
            3'b000:  w_load = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load = {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
            3'b011:  w_load = w_shift;
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_shift[7:0]};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_shift[15:0]};
            3'b110:  w_load = {{(XLEN-32){1'b0}}, w_shift[31:0]};
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_bmask_base = 8'h00;
        case (w_op_funct3[1:0])
            2'b00:   w_bmask_base = 8'h01;
            2'b01:   w_bmask_base = 8'h03;
            2'b10:   w_bmask_base = 8'h0F;
            default: w_bmask_base = 8'hFF;
        endcase
    end

    assign w_bmask = w_bmask_base << w_lane;

    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < XLEN / 8; b++) begin
            if (w_bmask[b]) begin
                w_merged[8*b +: 8] = w_wshift[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_funct3 <= 3'd0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_addr   <= bus.req_addr;
                r_funct3 <= bus.req_funct3;
                r_wdata  <= bus.req_wdata;
            end
            if (w_commit) begin
                r_fault <= w_fault;
                r_rdata <= (w_fault || w_op_write) ? '0 : w_load;
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && w_commit && w_op_write && !w_fault) begin
            mem[w_idx[AW-1:0]] <= w_merged;
        end
    end
endmodule
